// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and width helper for the systolic array controllers
package systolic_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_REUSE = 2'd2;
  // $clog2 returns 0 for 1, which would make a zero-width counter
  function automatic int clog2s(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ring_counter.sv
// ring_counter: mod-N counter with synchronous clear and enable, flagging the enabled terminal count
module ring_counter
  import systolic_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2s(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);
  localparam logic [W-1:0] LAST = W'(N - 1);
  logic [W-1:0] cnt;
  assign wrap = en && (cnt == LAST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr || wrap) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/shift_reg_seq_ctrl.sv
// shift_reg_seq_ctrl: fills a bank of circular line buffers, then recirculates each word
// NUM_PASSES times toward the systolic array with a valid/last strobe aligned to data_out.
module shift_reg_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int BUFFER_SIZE = 9,
  parameter int NUM_PASSES  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic src_valid,
  output logic src_ready,
  input  logic array_ready,
  output logic sr_in_valid,
  output logic sr_read_en,
  output logic out_valid,
  output logic out_last,
  output logic busy,
  output logic done
);
  localparam int EW = clog2s(BUFFER_SIZE);
  localparam int PW = $clog2(NUM_PASSES) + 1;
  logic [1:0] state, state_nxt;
  logic start_job, elem_wrap, pass_wrap, reuse_shift;
  assign start_job   = (state == ST_IDLE) && start;
  assign reuse_shift = (state == ST_REUSE) && array_ready;
  ring_counter #(.N(BUFFER_SIZE), .W(EW)) u_elem (
    .clk(clk), .rst_n(rst_n), .clr(start_job), .en(sr_in_valid), .wrap(elem_wrap)
  );
  // the pass counter only advances on element wraps during recirculation, so its wrap is the final shift
  ring_counter #(.N(NUM_PASSES), .W(PW)) u_pass (
    .clk(clk), .rst_n(rst_n), .clr(start_job), .en(elem_wrap && state == ST_REUSE), .wrap(pass_wrap)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = start_job ? ST_LOAD :
                (state == ST_LOAD && elem_wrap) ? ST_REUSE :
                pass_wrap ? ST_IDLE : state;
  end
  always_comb begin
    src_ready   = state == ST_LOAD;
    sr_read_en  = state == ST_LOAD;
    sr_in_valid = (state == ST_LOAD) ? src_valid : reuse_shift;
    busy        = state != ST_IDLE;
  end
  // strobes trail the shift by one cycle to line up with the buffer's registered data_out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {out_valid, out_last, done} <= '0;
    else begin
      out_valid <= reuse_shift;
      out_last  <= pass_wrap;
      done      <= pass_wrap;
    end
endmodule
